// File: rtl/b06_pkg.sv
// Shared definitions for the b06 handler and its requester: state encodings,
// cc_mux / uscite codes and the expected-output decode for each state.
package b06_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'b000,
    ST_WAIT   = 3'b001,
    ST_ENIN   = 3'b010,
    ST_ENIN_W = 3'b011,
    ST_INTR   = 3'b100,
    ST_INTR_1 = 3'b101,
    ST_INTR_W = 3'b110
  } b06_state_t;

  localparam logic [1:0] CC_NONE   = 2'b00;
  localparam logic [1:0] CC_NOP    = 2'b01;
  localparam logic [1:0] CC_ENIN   = 2'b01;
  localparam logic [1:0] CC_INTR   = 2'b10;
  localparam logic [1:0] CC_ACKIN  = 2'b11;

  localparam logic [1:0] US_ZERO   = 2'b00;
  localparam logic [1:0] US_NORM   = 2'b01;
  localparam logic [1:0] US_ELEVEN = 2'b11;

  // Returns {cc_mux, uscite} that the handler drives while in state s.
  function automatic logic [3:0] expected_outputs(b06_state_t s);
    logic [3:0] o;
    case (s)
      ST_INIT:   o = {CC_NONE, US_ZERO};
      ST_WAIT:   o = {CC_NOP, US_NORM};
      ST_ENIN_W: o = {CC_ENIN, US_NORM};
      ST_INTR_1: o = {CC_INTR, US_NORM};
      ST_ENIN:   o = {CC_ACKIN, US_ZERO};
      ST_INTR:   o = {CC_ACKIN, US_ZERO};
      ST_INTR_W: o = {CC_INTR, US_ELEVEN};
      default:   o = {CC_NONE, US_ZERO};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/b06_shadow.sv
// Shadow copy of the b06 handler FSM, stepped by our own eql, plus the
// {cc_mux, uscite} pair the real handler should be showing in that state.
module b06_shadow
  import b06_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       eql,
  output b06_state_t state,
  output logic [1:0] exp_cc,
  output logic [1:0] exp_us
);

  b06_state_t state_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_INIT;
    end else begin
      case (state_reg)
        ST_INIT:   state_reg <= ST_WAIT;
        ST_WAIT:   state_reg <= eql ? ST_ENIN   : ST_INTR_1;
        ST_INTR_1: state_reg <= eql ? ST_INTR   : ST_WAIT;
        ST_ENIN:   state_reg <= eql ? ST_ENIN   : ST_ENIN_W;
        ST_ENIN_W: state_reg <= eql ? ST_ENIN_W : ST_WAIT;
        ST_INTR:   state_reg <= eql ? ST_INTR   : ST_INTR_W;
        ST_INTR_W: state_reg <= eql ? ST_INTR_W : ST_WAIT;
        default:   state_reg <= ST_INIT;
      endcase
    end
  end

  assign state = state_reg;
  assign {exp_cc, exp_us} = expected_outputs(state_reg);

endmodule

// File: rtl/b06_requester.sv
// Bus-side agent for the b06 interrupt handler: sequences eql/cont_eql for
// enable/interrupt requests and flags divergence. Optional macro ACK_CHECK_EN.
module b06_requester
  import b06_pkg::*;
#(
  parameter int LEN_W = 4,
  parameter int ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_type,
  input  logic [LEN_W-1:0] req_len,
  output logic             eql,
  output logic             cont_eql,
  input  logic [1:0]       cc_mux,
  input  logic [1:0]       uscite,
  input  logic             ackout,
  input  logic             enable_count,
  output logic             busy,
  output logic             done,
  output logic             done_type,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  b06_state_t       state;
  logic [1:0]       exp_cc;
  logic [1:0]       exp_us;
  logic             pend_reg;
  logic             act_reg;
  logic             type_reg;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] hold_reg;
  logic             done_reg;
  logic             done_type_reg;
  logic             sync_err_reg;
  logic [ERR_W-1:0] err_cnt_reg;
  logic [LEN_W-1:0] hold_load;
  logic             in_hold;
  logic             accept;
  logic             start;
  logic             finish;
  logic             mismatch;

  b06_shadow u_shadow (
    .clock  (clock),
    .reset  (reset),
    .eql    (eql),
    .state  (state),
    .exp_cc (exp_cc),
    .exp_us (exp_us)
  );

  // eql depends only on registers, so no input can ripple through to the handler.
  always_comb begin
    eql = 1'b0;
    case (state)
      ST_WAIT:          eql = pend_reg & ~type_reg;
      ST_INTR_1:        eql = pend_reg & type_reg;
      ST_ENIN, ST_INTR: eql = (hold_reg != '0);
      default:          eql = 1'b0;
    endcase
  end

  assign in_hold   = (state == ST_ENIN) || (state == ST_INTR);
  assign cont_eql  = ~in_hold;
  assign busy      = pend_reg | act_reg;
  assign req_ready = ~busy;
  assign accept    = req_valid & req_ready;
  assign start     = pend_reg & eql & ((state == ST_WAIT) || (state == ST_INTR_1));
  assign finish    = act_reg & ~eql & ((state == ST_ENIN_W) || (state == ST_INTR_W));
  // A zero length behaves as one hold cycle.
  assign hold_load = (len_reg == '0) ? '0 : len_reg - LEN_W'(1);

`ifdef ACK_CHECK_EN
  logic exp_ack_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      exp_ack_reg <= 1'b0;
    end else begin
      exp_ack_reg <= ~cont_eql | ((state == ST_ENIN) & ~eql);
    end
  end

  assign mismatch = ({cc_mux, uscite} != {exp_cc, exp_us})
                  | (ackout != exp_ack_reg)
                  | (enable_count != exp_ack_reg);
`else
  logic unused_ack;
  assign unused_ack = ackout ^ enable_count;
  assign mismatch   = ({cc_mux, uscite} != {exp_cc, exp_us});
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_reg      <= 1'b0;
      act_reg       <= 1'b0;
      type_reg      <= 1'b0;
      len_reg       <= '0;
      hold_reg      <= '0;
      done_reg      <= 1'b0;
      done_type_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      done_reg <= finish;
      if (finish) begin
        done_type_reg <= type_reg;
        act_reg       <= 1'b0;
      end
      if (accept) begin
        pend_reg <= 1'b1;
        type_reg <= req_type;
        len_reg  <= req_len;
      end
      if (start) begin
        pend_reg <= 1'b0;
        act_reg  <= 1'b1;
        hold_reg <= hold_load;
      end else if (in_hold && (hold_reg != '0)) begin
        hold_reg <= hold_reg - LEN_W'(1);
      end
      // The shadow is never resynchronised; errors simply accumulate.
      if (mismatch) begin
        sync_err_reg <= 1'b1;
        if (err_cnt_reg != '1) begin
          err_cnt_reg <= err_cnt_reg + ERR_W'(1);
        end
      end
    end
  end

  assign done      = done_reg;
  assign done_type = done_type_reg;
  assign sync_err  = sync_err_reg;
  assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_b06_requester.sv
// Bench for b06_requester: a behavioural b06 handler answers the DUT's eql,
// and a transaction-level scoreboard checks timing, completion and errors.
module tb_b06_requester;

  localparam int LEN_W = 4;
  localparam int ERR_W = 8;

  localparam int H_INIT   = 0;
  localparam int H_WAIT   = 1;
  localparam int H_ENIN   = 2;
  localparam int H_ENIN_W = 3;
  localparam int H_INTR   = 4;
  localparam int H_INTR_1 = 5;
  localparam int H_INTR_W = 6;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_type = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic [1:0]       cc_mux = 2'b00;
  logic [1:0]       uscite = 2'b00;
  logic             ackout = 1'b0;
  logic             enable_count = 1'b0;
  logic             req_ready;
  logic             eql;
  logic             cont_eql;
  logic             busy;
  logic             done;
  logic             done_type;
  logic             sync_err;
  logic [ERR_W-1:0] err_cnt;

  always #5 clock = ~clock;

  b06_requester #(.LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_type     (req_type),
    .req_len      (req_len),
    .eql          (eql),
    .cont_eql     (cont_eql),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .ackout       (ackout),
    .enable_count (enable_count),
    .busy         (busy),
    .done         (done),
    .done_type    (done_type),
    .sync_err     (sync_err),
    .err_cnt      (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // handler model and scoreboard
  int h = H_INIT;
  int h_prev = H_INIT;
  bit force_cc = 0;
  bit force_ack = 0;
  bit ack_exp = 0;
  bit m_busy = 0;
  bit m_type = 0;
  bit m_sync = 0;
  bit last_acc = 0;
  bit saw_enin = 0;
  bit saw_intr = 0;
  int m_len = 0;
  int m_err = 0;
  int age = 0;
  int eql_cnt = 0;
  int cont_cnt = 0;

  function automatic logic [3:0] hout(int s);
    case (s)
      H_INIT:   return 4'b0000;
      H_WAIT:   return 4'b0101;
      H_INTR_1: return 4'b1001;
      H_ENIN:   return 4'b1100;
      H_ENIN_W: return 4'b0101;
      H_INTR:   return 4'b1100;
      H_INTR_W: return 4'b1011;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic int hnext(int s, logic e);
    case (s)
      H_INIT:   return H_WAIT;
      H_WAIT:   return e ? H_ENIN : H_INTR_1;
      H_INTR_1: return e ? H_INTR : H_WAIT;
      H_ENIN:   return e ? H_ENIN : H_ENIN_W;
      H_ENIN_W: return e ? H_ENIN_W : H_WAIT;
      H_INTR:   return e ? H_INTR : H_INTR_W;
      H_INTR_W: return e ? H_INTR_W : H_WAIT;
      default:  return H_INIT;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_handler();
    logic [3:0] o;
    o = hout(h);
    if (force_cc) o[3:2] = 2'b00;
    {cc_mux, uscite} = o;
    ackout = ack_exp ^ force_ack;
    enable_count = ack_exp;
  endtask

  // One clock cycle: handler answers, scoreboard updates, per-cycle checks.
  task automatic tick();
    int hn;
    bit mm, acc, e, ack_n, exp_done, in_hold;
    drive_handler();
    #1;
    e = eql;
    acc = !reset && req_valid && !m_busy;
    hn = reset ? H_INIT : hnext(h, e);
    mm = !reset && ({cc_mux, uscite} != hout(h));
`ifdef ACK_CHECK_EN
    mm = mm || (!reset && ((ackout != ack_exp) || (enable_count != ack_exp)));
`endif
    in_hold = (h == H_ENIN) || (h == H_INTR);
    ack_n = reset ? 1'b0 : (in_hold || ((h == H_ENIN) && !e));
    @(posedge clock);
    #1;
    h_prev = h;
    h = hn;
    ack_exp = ack_n;
    last_acc = acc;
    exp_done = 0;
    if (reset) begin
      m_err = 0;
      m_sync = 0;
      m_busy = 0;
    end else begin
      if (mm) begin
        m_sync = 1;
        if (m_err < 255) m_err++;
      end
      exp_done = m_busy && (h == H_WAIT) && ((h_prev == H_ENIN_W) || (h_prev == H_INTR_W));
      if (exp_done) begin
        check("done_type", done_type, m_type);
        check("eql_cycles", eql_cnt, (m_len == 0) ? 1 : m_len);
        check("cont_low_cycles", cont_cnt, (m_len == 0) ? 1 : m_len);
        check("path", {saw_enin, saw_intr}, m_type ? 2'b01 : 2'b10);
        m_busy = 0;
      end
      if (acc) begin
        m_busy = 1;
        m_type = req_type;
        m_len = int'(req_len);
        eql_cnt = 0;
        cont_cnt = 0;
        saw_enin = 0;
        saw_intr = 0;
        age = 0;
      end
      if (m_busy) begin
        eql_cnt += int'(eql);
        cont_cnt += int'(!cont_eql);
        saw_enin |= (h == H_ENIN);
        saw_intr |= (h == H_INTR);
        age++;
        check("txn_age_bound", age <= 80, 1);
      end else begin
        check("idle_eql", eql, 0);
      end
    end
    check("done", done, exp_done);
    check("req_ready", req_ready, !m_busy);
    check("busy", busy, m_busy);
    check("cont_eql", cont_eql, !((h == H_ENIN) || (h == H_INTR)));
    check("sync_err", sync_err, m_sync);
    check("err_cnt", err_cnt, m_err);
  endtask

  task automatic send(bit t, int l);
    req_valid = 1'b1;
    req_type = t;
    req_len = LEN_W'(l);
    last_acc = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) break;
    end
    check("accepted", last_acc, 1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_busy; i++) tick();
    check("idle_reached", m_busy, 0);
  endtask

  initial begin
    // reset and idle alternation
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("rst_eql", eql, 0);
    check("rst_cont_eql", cont_eql, 1);
    check("rst_busy", busy, 0);
    check("rst_done_type", done_type, 0);
    check("rst_err_cnt", err_cnt, 0);
    repeat (10) tick();
    check("idle_sync_err", sync_err, 0);

    // directed enable, interrupt len 0, back-to-back
    send(1'b0, 3);
    wait_idle();
    tick();
    send(1'b1, 0);
    wait_idle();
    tick();
    send(1'b0, 2);
    send(1'b1, 5);
    wait_idle();

    // random traffic
    repeat (40) begin
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
    tick();

    // corrupt ackout on the ENIN exit
    send(1'b0, 2);
    for (int i = 0; i < 40 && h != H_ENIN_W; i++) tick();
    check("reach_enin_w", h == H_ENIN_W, 1);
    force_ack = 1;
    tick();
    force_ack = 0;
    wait_idle();
    tick();

    // single-cycle cc_mux corruption in WAIT, then saturation
    for (int i = 0; i < 10 && h != H_WAIT; i++) tick();
    force_cc = 1;
    tick();
    force_cc = 0;
    check("sync_err_set", sync_err, 1);
    repeat (5) tick();
    force_cc = 1;
    repeat (300) tick();
    force_cc = 0;
    tick();
    check("err_saturated", err_cnt, 255);

    // reset mid-interrupt with a request on the port
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    send(1'b1, 8);
    for (int i = 0; i < 40 && h != H_INTR; i++) tick();
    check("reach_intr", h == H_INTR, 1);
    req_valid = 1'b1;
    req_type = 1'b0;
    req_len = 4'd3;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    check("mid_rst_eql", eql, 0);
    check("mid_rst_cont_eql", cont_eql, 1);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
